didactic_reset_seq: RTL

//   Reset sequencer on the consumer side of the board PLL. Runs on the PLL

---
 rtl/didactic_fpga_pkg.sv | 22 ++
 rtl/didactic_sync_debounce.sv | 58 +++++
 rtl/didactic_reset_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/didactic_fpga_pkg.sv
// Shared definitions for the Didactic FPGA top: the sequencer state encoding
// and the default timing constants for the 8 MHz PLL output clock.
package didactic_fpga_pkg;

    typedef enum logic [2:0] {
        SEQ_WAIT_LOCK = 3'd0,
        SEQ_STABLE    = 3'd1,
        SEQ_RELEASE   = 3'd2,
        SEQ_RUN       = 3'd3
    } seq_state_e;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int LOCK_STABLE_CYC_DEF = 1024;
    localparam int DEBOUNCE_CYC_DEF    = 8000;   // 1 ms at 8 MHz
    localparam int RELEASE_DLY_CYC_DEF = 16;
    localparam int LOST_CNT_W_DEF      = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/didactic_sync_debounce.sv
// Multi-flop synchronizer followed by an optional level filter. With
// DEBOUNCE_CYC = 0 the filter is removed and level is the synchronized input.
module didactic_sync_debounce
    import didactic_fpga_pkg::*;
#(
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk_in,
    input  logic reset,
    input  logic din,
    output logic level
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYC == 0) begin : g_bypass
            assign level = synced;
        end else begin : g_filter
            localparam int            DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
            localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYC - 1);

            logic [DW-1:0] cnt_q;
            logic          level_q;

            // Accept a new level only after it has differed for DEBOUNCE_CYC cycles in a row.
            always_ff @(posedge clk_in or negedge reset) begin
                if (!reset) begin
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end else if (synced == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == LAST) begin
                    level_q <= synced;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + DW'(1);
                end
            end

            assign level = level_q;
        end
    endgenerate

endmodule

// File: rtl/didactic_reset_seq.sv
// Reset sequencer between the board PLL and the Didactic SoC.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   WAIT_LOCK   | SoC held in reset until lock is seen and button released
//   STABLE      | counting LOCK_STABLE_CYC consecutive locked cycles
//   RELEASE     | extra RELEASE_DLY_CYC cycles before letting the SoC go
//   RUN         | SoC out of reset; lock loss is recorded and counted
module didactic_reset_seq
    import didactic_fpga_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int LOCK_STABLE_CYC = LOCK_STABLE_CYC_DEF,
    parameter int DEBOUNCE_CYC    = DEBOUNCE_CYC_DEF,
    parameter int RELEASE_DLY_CYC = RELEASE_DLY_CYC_DEF,
    parameter int LOST_CNT_W      = LOST_CNT_W_DEF
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  pll_locked,
    input  logic                  btn_reset,
    input  logic                  clear_lost,
    output logic                  soc_rst_n,
    output logic [2:0]            seq_state,
    output logic                  lock_lost,
    output logic [LOST_CNT_W-1:0] lost_count
);

    localparam int               CNT_W        = $clog2(max_int(LOCK_STABLE_CYC, RELEASE_DLY_CYC) + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_DLY_CYC - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lk_s;
    logic             bt_d;
    logic             loss_evt;

    // PLL lock is a clean level, so only its synchronizer is used.
    didactic_sync_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (0)
    ) u_lock_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .din    (pll_locked),
        .level  (lk_s)
    );

    didactic_sync_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .din    (btn_reset),
        .level  (bt_d)
    );

    // State and phase counter registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= SEQ_WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a lock drop in RUN takes priority over the button.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_evt = 1'b0;
        case (state_q)
            SEQ_WAIT_LOCK: begin
                cnt_d = '0;
                if (lk_s && !bt_d) state_d = SEQ_STABLE;
            end
            SEQ_STABLE: begin
                if (!lk_s || bt_d) begin
                    state_d = SEQ_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = SEQ_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEQ_RELEASE: begin
                if (!lk_s || bt_d) begin
                    state_d = SEQ_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == RELEASE_LAST) begin
                    state_d = SEQ_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEQ_RUN: begin
                cnt_d = '0;
                if (!lk_s) begin
                    state_d  = SEQ_WAIT_LOCK;
                    loss_evt = 1'b1;
                end else if (bt_d) begin
                    state_d = SEQ_WAIT_LOCK;
                end
            end
            default: begin
                state_d = SEQ_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered SoC reset plus lock-loss bookkeeping; a loss beats a same-cycle clear.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            soc_rst_n  <= 1'b0;
            lock_lost  <= 1'b0;
            lost_count <= '0;
        end else begin
            soc_rst_n <= (state_q == SEQ_RUN);
            if (loss_evt) begin
                lock_lost <= 1'b1;
                if (clear_lost) begin
                    lost_count <= LOST_CNT_W'(1);
                end else if (lost_count != '1) begin
                    lost_count <= lost_count + LOST_CNT_W'(1);
                end
            end else if (clear_lost) begin
                lock_lost  <= 1'b0;
                lost_count <= '0;
            end
        end
    end

    assign seq_state = state_q;

endmodule
